// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one byte-level UART transmitter.
// Each requester offers a BYTES-byte packet; the winner is captured into a
// shift register and fed to the transmitter most significant byte first.
// A per-byte watchdog abandons the packet if tx_done never comes back.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no packet in flight; arbitrate among pending requesters
// START | tx_start/tx_data presented for one cycle, watchdog cleared
// WAIT  | byte in flight; waiting for tx_done or watchdog expiry

module uart_tx_scheduler #(
    parameter int DBITS   = 8,
    parameter int NREQ    = 4,
    parameter int ID_BITS = 2,
    parameter int BYTES   = 4,
    parameter int TIMEOUT = 4096,
    parameter int TO_BITS = 13
) (
    input  logic                        clk_100MHz,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ*BYTES*DBITS-1:0] req_data,
    output logic [NREQ-1:0]             ack,
    output logic [NREQ-1:0]             done,
    output logic                        timeout_err,
    output logic                        busy,
    output logic [ID_BITS-1:0]          grant_id,
    output logic                        tx_start,
    output logic [DBITS-1:0]            tx_data,
    input  logic                        tx_done
);

    localparam int PKT   = BYTES * DBITS;
    localparam int CNT_W = $clog2(BYTES + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

    state_t             state_q, state_d;
    logic [PKT-1:0]     sr_q, sr_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [ID_BITS-1:0] ptr_q, ptr_d;
    logic [TO_BITS-1:0] wd_q, wd_d;
    logic [NREQ-1:0]    ack_q, ack_d;
    logic [NREQ-1:0]    done_q, done_d;
    logic               timeout_err_q, timeout_err_d;
    logic               busy_q, busy_d;
    logic [ID_BITS-1:0] grant_id_q, grant_id_d;
    logic               tx_start_q, tx_start_d;
    logic [DBITS-1:0]   tx_data_q, tx_data_d;

    logic [PKT-1:0]     pkt_arr [NREQ];
    logic [PKT-1:0]     win_pkt;
    logic [PKT-1:0]     sr_shift;
    logic [ID_BITS-1:0] win_id;
    logic [ID_BITS-1:0] cand;
    logic               win_found;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign pkt_arr[g] = req_data[g*PKT +: PKT];
    end

    assign sr_shift = sr_q << DBITS;

    // Round-robin pick: first pending requester after the last grantee.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = ID_BITS'((int'(ptr_q) + i) % NREQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
        win_pkt = pkt_arr[win_id];
    end

    // Next-state and registered-output computation for the sequencer.
    always_comb begin
        state_d       = state_q;
        sr_d          = sr_q;
        byte_cnt_d    = byte_cnt_q;
        ptr_d         = ptr_q;
        wd_d          = wd_q;
        ack_d         = '0;
        done_d        = '0;
        timeout_err_d = 1'b0;
        busy_d        = busy_q;
        grant_id_d    = grant_id_q;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data_q;

        case (state_q)
            S_IDLE: begin
                // Outputs are registered, so the START-cycle strobes are
                // loaded on the transition into START.
                if (win_found) begin
                    sr_d          = win_pkt;
                    byte_cnt_d    = CNT_W'(BYTES);
                    grant_id_d    = win_id;
                    ptr_d         = win_id;
                    busy_d        = 1'b1;
                    ack_d[win_id] = 1'b1;
                    tx_start_d    = 1'b1;
                    tx_data_d     = win_pkt[PKT-1 -: DBITS];
                    state_d       = S_START;
                end
            end
            S_START: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // tx_done takes priority over a watchdog expiring together.
                if (tx_done) begin
                    if (byte_cnt_q == CNT_W'(1)) begin
                        done_d[grant_id_q] = 1'b1;
                        busy_d             = 1'b0;
                        state_d            = S_IDLE;
                    end else begin
                        sr_d       = sr_shift;
                        byte_cnt_d = byte_cnt_q - CNT_W'(1);
                        tx_start_d = 1'b1;
                        tx_data_d  = sr_shift[PKT-1 -: DBITS];
                        state_d    = S_START;
                    end
                end else if (wd_q == TO_BITS'(TIMEOUT - 2)) begin
                    // Counter would reach TIMEOUT-1 this cycle; registering
                    // the abort lands it TIMEOUT cycles after tx_start.
                    timeout_err_d = 1'b1;
                    busy_d        = 1'b0;
                    state_d       = S_IDLE;
                end else begin
                    wd_d = wd_q + TO_BITS'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; async reset returns everything to idle.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            sr_q          <= '0;
            byte_cnt_q    <= '0;
            ptr_q         <= ID_BITS'(NREQ - 1);
            wd_q          <= '0;
            ack_q         <= '0;
            done_q        <= '0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
            grant_id_q    <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            byte_cnt_q    <= byte_cnt_d;
            ptr_q         <= ptr_d;
            wd_q          <= wd_d;
            ack_q         <= ack_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
            grant_id_q    <= grant_id_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
        end
    end

    assign ack         = ack_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;
    assign grant_id    = grant_id_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: stimulus pushes the expected
// ack / byte / done / timeout events, a negedge monitor pops and compares
// them as the DUT emits them. Cycle stamps are logged for latency checks.

module tb_uart_tx_scheduler;

    localparam int NREQ    = 4;
    localparam int BYTES   = 4;
    localparam int DBITS   = 8;
    localparam int TIMEOUT = 64;

    logic         clk_100MHz = 1'b0;
    logic         reset      = 1'b1;
    logic [3:0]   req;
    logic [127:0] req_data;
    logic [3:0]   ack;
    logic [3:0]   done;
    logic         timeout_err;
    logic         busy;
    logic [1:0]   grant_id;
    logic         tx_start;
    logic [7:0]   tx_data;
    logic         tx_done = 1'b0;

    logic [31:0] pkt [4] = '{default: 32'h0};
    int quota [4] = '{default: 0};
    int acks  [4] = '{default: 0};

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    int tx_lat   = 20;
    bit model_on = 1'b1;
    int cnt      = 0;
    int inj_req  = 0;
    int inj_seen = 0;

    int         exp_ack  [$];
    logic [9:0] exp_tx   [$];
    int         exp_done [$];
    int         exp_to   [$];
    int ack_log [$];
    int tx_log  [$];
    int done_log[$];
    int to_log  [$];

    uart_tx_scheduler #(
        .DBITS(DBITS), .NREQ(NREQ), .ID_BITS(2), .BYTES(BYTES),
        .TIMEOUT(TIMEOUT), .TO_BITS(13)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .done       (done),
        .timeout_err(timeout_err),
        .busy       (busy),
        .grant_id   (grant_id),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_done    (tx_done)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    assign req_data = {pkt[3], pkt[2], pkt[1], pkt[0]};

    // A requester holds req until it has been acked quota times.
    always_comb begin
        req = '0;
        for (int i = 0; i < 4; i++) req[i] = (acks[i] < quota[i]);
    end

    always @(posedge clk_100MHz) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_evt(input string name);
        n_chk++;
        $display("FAIL %s: actual unexpected event, required none (cycle %0d)", name, cyc);
    endtask

    // Requester model: count acks so req drops once the quota is served.
    always @(negedge clk_100MHz) begin
        if (!reset)
            for (int i = 0; i < 4; i++)
                if (ack[i] === 1'b1) acks[i] = acks[i] + 1;
    end

    // Transmitter model: tx_done tx_lat cycles after tx_start, plus injected strays.
    always @(negedge clk_100MHz) begin
        tx_done = 1'b0;
        if (reset) begin
            cnt = 0;
        end else begin
            if (cnt > 0) begin
                cnt = cnt - 1;
                if (cnt == 0) tx_done = 1'b1;
            end
            if (inj_req != inj_seen) begin
                tx_done  = 1'b1;
                inj_seen = inj_req;
            end
            if (tx_start === 1'b1 && model_on) cnt = tx_lat;
        end
    end

    // Monitor: pop and compare every event the DUT presents.
    always @(negedge clk_100MHz) begin
        int         e;
        logic [9:0] t;
        if (!reset) begin
            if ((|ack) === 1'b1) begin
                if (exp_ack.size() == 0) fail_evt("ack_unexpected");
                else begin
                    e = exp_ack.pop_front();
                    chk("ack_vec", 64'(ack), 64'(1 << e));
                    chk("ack_grant_id", 64'(grant_id), 64'(e));
                    chk("busy_at_ack", 64'(busy), 64'(1));
                end
                ack_log.push_back(cyc);
            end
            if (tx_start === 1'b1) begin
                if (exp_tx.size() == 0) fail_evt("tx_start_unexpected");
                else begin
                    t = exp_tx.pop_front();
                    chk("tx_data", 64'(tx_data), 64'(t[7:0]));
                    chk("tx_grant_id", 64'(grant_id), 64'(t[9:8]));
                end
                tx_log.push_back(cyc);
            end
            if ((|done) === 1'b1) begin
                if (exp_done.size() == 0) fail_evt("done_unexpected");
                else begin
                    e = exp_done.pop_front();
                    chk("done_vec", 64'(done), 64'(1 << e));
                    chk("busy_at_done", 64'(busy), 64'(0));
                end
                done_log.push_back(cyc);
            end
            if (timeout_err === 1'b1) begin
                if (exp_to.size() == 0) fail_evt("timeout_unexpected");
                else begin
                    e = exp_to.pop_front();
                    chk("busy_at_timeout", 64'(busy), 64'(0));
                end
                to_log.push_back(cyc);
            end
        end
    end

    task automatic push_pkt(input int id, input logic [31:0] d, input int nbytes, input bit fin);
        logic [7:0] by;
        exp_ack.push_back(id);
        for (int b = 0; b < nbytes; b++) begin
            by = d[31-8*b -: 8];
            exp_tx.push_back({id[1:0], by});
        end
        if (fin) exp_done.push_back(id);
    endtask

    function automatic int pending();
        return exp_ack.size() + exp_tx.size() + exp_done.size() + exp_to.size();
    endfunction

    task automatic drain(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (pending() == 0) break;
            @(negedge clk_100MHz); #1;
        end
        chk(name, 64'(pending()), 64'(0));
        repeat (3) @(negedge clk_100MHz);
        #1;
    endtask

    task automatic wait_tx(input int n, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (tx_log.size() >= n) break;
            @(negedge clk_100MHz); #1;
        end
        chk(name, 64'(tx_log.size() >= n), 64'(1));
    endtask

    task automatic clear_logs();
        ack_log.delete(); tx_log.delete(); done_log.delete(); to_log.delete();
    endtask

    task automatic reset_pulse(input string tag);
        exp_ack.delete(); exp_tx.delete(); exp_done.delete(); exp_to.delete();
        reset = 1'b1;
        #1;
        chk({tag, "_ack"}, 64'(ack), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_timeout_err"}, 64'(timeout_err), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_tx_start"}, 64'(tx_start), 64'(0));
        chk({tag, "_tx_data"}, 64'(tx_data), 64'(0));
        chk({tag, "_grant_id"}, 64'(grant_id), 64'(0));
        repeat (2) @(negedge clk_100MHz);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual simulation still running, required finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int t;
        @(negedge clk_100MHz); #1;
        reset_pulse("por");

        // 1: single packet from requester 2, 20-cycle transmitter
        clear_logs();
        pkt[2] = 32'hA1B2C3D4;
        tx_lat = 20; model_on = 1'b1;
        push_pkt(2, pkt[2], 4, 1'b1);
        t = cyc;
        quota[2] = acks[2] + 1;
        drain(300, "t1_drain");
        chk("t1_ack_count", 64'(ack_log.size()), 64'(1));
        if (ack_log.size() == 1 && tx_log.size() == 4 && done_log.size() == 1) begin
            chk("t1_ack_latency", 64'(ack_log[0]), 64'(t + 1));
            chk("t1_first_tx", 64'(tx_log[0]), 64'(t + 1));
            for (int k = 0; k < 3; k++) chk("t1_byte_gap", 64'(tx_log[k+1] - tx_log[k]), 64'(21));
            chk("t1_done_latency", 64'(done_log[0]), 64'(tx_log[3] + 21));
        end else fail_evt("t1_event_count");
        chk("t1_grant_id", 64'(grant_id), 64'(2));
        chk("t1_busy_idle", 64'(busy), 64'(0));

        // 2: requesters 0 and 1 held high, two packets each, must alternate
        clear_logs();
        pkt[0] = 32'h10111213; pkt[1] = 32'h20212223;
        tx_lat = 3;
        push_pkt(0, pkt[0], 4, 1'b1); push_pkt(1, pkt[1], 4, 1'b1);
        push_pkt(0, pkt[0], 4, 1'b1); push_pkt(1, pkt[1], 4, 1'b1);
        t = cyc;
        quota[0] = acks[0] + 2; quota[1] = acks[1] + 2;
        drain(500, "t2_drain");
        if (ack_log.size() == 4 && done_log.size() == 4 && tx_log.size() == 16) begin
            chk("t2_ack_latency", 64'(ack_log[0]), 64'(t + 1));
            for (int k = 0; k < 3; k++) chk("t2_done_to_ack", 64'(ack_log[k+1] - done_log[k]), 64'(1));
            for (int k = 0; k < 4; k++) chk("t2_done_latency", 64'(done_log[k] - tx_log[4*k+3]), 64'(4));
        end else fail_evt("t2_event_count");

        // 3: all four pending out of reset, order 0,1,2,3,0
        reset_pulse("t3_rst");
        clear_logs();
        pkt[0] = 32'h01020304; pkt[1] = 32'h11121314;
        pkt[2] = 32'h21222324; pkt[3] = 32'h31323334;
        push_pkt(0, pkt[0], 4, 1'b1); push_pkt(1, pkt[1], 4, 1'b1);
        push_pkt(2, pkt[2], 4, 1'b1); push_pkt(3, pkt[3], 4, 1'b1);
        push_pkt(0, pkt[0], 4, 1'b1);
        quota[0] = acks[0] + 2; quota[1] = acks[1] + 1;
        quota[2] = acks[2] + 1; quota[3] = acks[3] + 1;
        drain(800, "t3_drain");
        chk("t3_ack_count", 64'(ack_log.size()), 64'(5));

        // 4: transmitter silent -> watchdog abort, then pending req[3] served
        clear_logs();
        model_on = 1'b0;
        pkt[1] = 32'hDEADBEEF;
        push_pkt(1, pkt[1], 1, 1'b0);
        exp_to.push_back(1);
        quota[1] = acks[1] + 1;
        wait_tx(1, 20, "t4_first_tx");
        model_on = 1'b1; tx_lat = 3;
        pkt[3] = 32'h0F1E2D3C;
        push_pkt(3, pkt[3], 4, 1'b1);
        quota[3] = acks[3] + 1;
        drain(400, "t4_drain");
        if (to_log.size() == 1 && tx_log.size() == 5 && ack_log.size() == 2) begin
            chk("t4_timeout_latency", 64'(to_log[0] - tx_log[0]), 64'(TIMEOUT));
            chk("t4_next_ack", 64'(ack_log[1] - to_log[0]), 64'(1));
            chk("t4_next_tx", 64'(tx_log[1] - to_log[0]), 64'(1));
        end else fail_evt("t4_event_count");
        chk("t4_done_count", 64'(done_log.size()), 64'(1));

        // 5: reset in WAIT after second byte, then requester 3 wins first
        clear_logs();
        tx_lat = 5;
        pkt[1] = 32'h11223344;
        push_pkt(1, pkt[1], 4, 1'b1);
        quota[1] = acks[1] + 1;
        wait_tx(2, 100, "t5_two_bytes");
        repeat (2) @(negedge clk_100MHz);
        #1;
        reset_pulse("t5_rst");
        clear_logs();
        pkt[3] = 32'h99AABBCC;
        push_pkt(3, pkt[3], 4, 1'b1);
        t = cyc;
        quota[3] = acks[3] + 1;
        drain(300, "t5_drain");
        if (ack_log.size() == 1) chk("t5_ack_latency", 64'(ack_log[0]), 64'(t + 1));
        else fail_evt("t5_event_count");

        // 6: stray tx_done in IDLE and in START must be ignored
        clear_logs();
        tx_lat = 10;
        inj_req = inj_req + 1;
        repeat (4) @(negedge clk_100MHz);
        #1;
        chk("t6_idle_busy", 64'(busy), 64'(0));
        chk("t6_idle_tx", 64'(tx_log.size()), 64'(0));
        pkt[0] = 32'h5A6B7C8D;
        push_pkt(0, pkt[0], 4, 1'b1);
        quota[0] = acks[0] + 1;
        @(posedge clk_100MHz); #1;
        inj_req = inj_req + 1;
        drain(300, "t6_drain");
        if (tx_log.size() == 4 && done_log.size() == 1) begin
            for (int k = 0; k < 3; k++) chk("t6_byte_gap", 64'(tx_log[k+1] - tx_log[k]), 64'(11));
            chk("t6_done_latency", 64'(done_log[0] - tx_log[3]), 64'(11));
        end else fail_evt("t6_event_count");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares one byte-level UART transmitter among NREQ requesters. Each requester offers a fixed-length packet of BYTES bytes. The block arbitrates, captures the winning packet and sequences it byte by byte into the transmitter through a start/done handshake. A per-byte watchdog aborts a packet if the transmitter stalls. It sits between the coprocessor's command logic and the uart_transmitter, replacing the single-shot tx_trigger path with multi-client access.

## Interface
- DBITS, 8, bits per UART byte
- NREQ, 4, number of requesters
- ID_BITS, 2, width of grant_id; must satisfy 2**ID_BITS >= NREQ
- BYTES, 4, bytes per packet (>= 1)
- TIMEOUT, 4096, cycles allowed from tx_start to tx_done before abort (>= 2)
- TO_BITS, 13, watchdog counter width; must satisfy 2**TO_BITS > TIMEOUT

- clk_100MHz  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req  in  NREQ  req[i] high = requester i has a packet; held until ack[i]
- req_data  in  NREQ*BYTES*DBITS  packet of requester i is slice [i*BYTES*DBITS +: BYTES*DBITS]; its most significant byte is sent first
- ack  out  NREQ  one-cycle pulse: packet of requester i captured; requester may change data and drop req
- done  out  NREQ  one-cycle pulse: last byte of requester i's packet completed
- timeout_err  out  1  one-cycle pulse: current packet aborted by watchdog
- busy  out  1  high from capture until done, abort or reset
- grant_id  out  ID_BITS  index of the current or most recent grantee
- tx_start  out  1  one-cycle pulse: transmitter starts sending tx_data
- tx_data  out  DBITS  byte to send; stable from tx_start until tx_done
- tx_done  in  1  one-cycle pulse from transmitter after the stop bit

## Operation
- State machine: IDLE, START, WAIT.
- IDLE:
  - If req is nonzero, choose a winner by round robin. Search order is ptr+1, ptr+2, … modulo NREQ, where ptr is the last granted index.
  - At the next edge: load the winner's req_data into shift register sr, set byte_cnt = BYTES, set grant_id and ptr to the winner, set busy = 1, go to START.
- START (exactly one cycle):
  - ack[grant_id] = 1 only on the first START of a packet.
  - tx_start = 1 and tx_data = sr[top DBITS].
  - Watchdog cleared. Go to WAIT.
- WAIT:
  - The watchdog increments each cycle.
  - On tx_done with byte_cnt == 1: done[grant_id] pulses, busy = 0, go to IDLE.
  - On tx_done with byte_cnt > 1: shift sr left by DBITS, decrement byte_cnt, go to START.
  - If the watchdog reaches TIMEOUT-1 without tx_done: timeout_err pulses, busy = 0, go to IDLE. done is not pulsed and remaining bytes are dropped.
  - If tx_done arrives in the same cycle the watchdog expires, tx_done wins.
- tx_done is ignored in IDLE and START.
- req changes while busy are ignored. A requester whose req is still high after its ack competes again in the next IDLE.
- All outputs are registered.

## Timing
- Reset values:
  - state = IDLE; ack, done, timeout_err, busy, tx_start = 0.
  - tx_data = 0, grant_id = 0, byte_cnt = 0.
  - ptr = NREQ-1, so requester 0 wins first after reset.
- Acceptance latency:
  - req sampled high in IDLE cycle t → ack and first tx_start both high in cycle t+1.
  - busy goes high in cycle t+1.
- Byte-to-byte: tx_done in cycle k → next tx_start in cycle k+1.
- Packet end:
  - final tx_done in cycle k → done high in cycle k+1 and busy low in cycle k+1.
  - The state is IDLE in cycle k+1, so the next ack is possible at k+2.
- Back-to-back packets therefore have one dead cycle between done and the next tx_start.
- Watchdog: abort occurs TIMEOUT cycles after tx_start if tx_done never arrives.
- Reset mid-packet: immediate return to IDLE; no done or timeout_err is generated; the transmitter is not signalled further.

## Test plan
- NREQ=4, BYTES=4. req[2] with packet 0xA1B2C3D4; transmitter model returns tx_done 20 cycles after each tx_start → ack[2] in the cycle after req, tx_data sequence A1, B2, C3, D4, done[2] one cycle after the 4th tx_done, grant_id = 2.
- req = 4'b0011 held continuously, re-raised after each ack → grants alternate 0, 1, 0, 1; no requester is granted twice in a row.
- All four req high from reset → grant order 0, 1, 2, 3, 0; each packet's bytes are contiguous with no interleaving.
- Transmitter never returns tx_done, TIMEOUT=64 → timeout_err pulses 64 cycles after the first tx_start, no done, busy low; a pending req is then accepted normally.
- Reset asserted in WAIT after byte 2 → all outputs 0 immediately; after release, req[3] is granted with tx_data equal to its first byte.
- tx_done pulsed in IDLE and again during a START cycle → ignored; byte_cnt is unchanged and no extra tx_start is issued.
